// File: rtl/imem_loader.sv
// Writable instruction memory: a host load port streams program words in, a registered
// fetch port serves the core, and per-word valid bits turn bad fetches into ILLOP + fault.
module imem_loader #(
    parameter int                 DATA_W      = 32,
    parameter int                 DEPTH       = 128,
    parameter int                 ADDR_W      = 7,
    parameter logic [DATA_W-1:0]  ILLOP_INSTR = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_start,
    input  logic [ADDR_W-1:0] i_load_base,
    input  logic              i_load_valid,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_load_last,
    output logic              o_load_ready,
    output logic              o_load_done,
    output logic              o_load_err,
    output logic [DATA_W-1:0] o_load_sum,
    input  logic              i_fetch_en,
    input  logic [31:0]       i_pc,
    output logic [DATA_W-1:0] o_instr,
    output logic              o_instr_valid,
    output logic              o_fetch_fault,
    output logic              o_busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] IDX_MAX = '1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [DATA_W-1:0] r_sum;
    logic              r_err;
    logic              r_done;
    logic              r_busy;
    logic [DATA_W-1:0] r_instr;
    logic              r_instr_valid;
    logic              r_fault;

    logic              w_accept;
    logic              w_idx_ok;
    logic              w_fetch_acc;
    logic [31:0]       w_word;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_fidx;
    logic              w_fault;

    // A word coinciding with load_start belongs to the abandoned session and is discarded.
    assign w_accept    = (r_state == S_LOAD) && i_load_valid && !i_load_start;
    assign w_idx_ok    = (32'(r_idx) < 32'(DEPTH));
    assign w_fetch_acc = i_fetch_en && (r_state == S_IDLE);
    assign w_word      = {2'b00, i_pc[31:2]};
    assign w_in_range  = (w_word < 32'(DEPTH));
    assign w_fidx      = i_pc[ADDR_W+1:2];
    assign w_fault     = (i_pc[1:0] != 2'b00) || !w_in_range || !r_valid[w_fidx];

    // Program storage; contents survive reset, only the valid vector is cleared.
    always_ff @(posedge i_clk) begin
        if (w_accept && w_idx_ok) begin
            r_mem[r_idx] <= i_load_data;
        end
    end

    // Load FSM, valid bits, checksum and the registered fetch port.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_valid       <= '0;
            r_sum         <= '0;
            r_err         <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_instr       <= ILLOP_INSTR;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_done        <= w_accept && i_load_last;
            r_instr_valid <= w_fetch_acc;
            r_fault       <= w_fetch_acc && w_fault;
            if (w_fetch_acc) begin
                r_instr <= w_fault ? ILLOP_INSTR : r_mem[w_fidx];
            end

            if (i_load_start) begin
                r_state <= S_LOAD;
                r_busy  <= 1'b1;
                r_idx   <= i_load_base;
                r_sum   <= '0;
                r_err   <= 1'b0;
                r_valid <= '0;
            end else if (w_accept) begin
                if (w_idx_ok) begin
                    r_valid[r_idx] <= 1'b1;
                    r_sum          <= r_sum + i_load_data;
                end else begin
                    r_err <= 1'b1;
                end
                // Index saturates rather than wrapping onto already-loaded words.
                if (r_idx != IDX_MAX) begin
                    r_idx <= r_idx + 1'b1;
                end
                if (i_load_last) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            end
        end
    end

    assign o_load_ready  = r_busy;
    assign o_busy        = r_busy;
    assign o_load_done   = r_done;
    assign o_load_err    = r_err;
    assign o_load_sum    = r_sum;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_fetch_fault = r_fault;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: fetch expectations are queued by the stimulus and
// checked by an independent monitor whenever the DUT presents instr_valid.
module tb_imem_loader;

    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 120;
    localparam int          ADDR_W = 7;
    localparam logic [31:0] ILLOP  = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_start = 1'b0;
    logic [ADDR_W-1:0] load_base = '0;
    logic              load_valid = 1'b0;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_last = 1'b0;
    logic              load_ready;
    logic              load_done;
    logic              load_err;
    logic [DATA_W-1:0] load_sum;
    logic              fetch_en = 1'b0;
    logic [31:0]       pc = '0;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              fetch_fault;
    logic              busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] exp_q [$];
    logic [32:0] mon_e;

    imem_loader #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .ILLOP_INSTR (ILLOP)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_load_start  (load_start),
        .i_load_base   (load_base),
        .i_load_valid  (load_valid),
        .i_load_data   (load_data),
        .i_load_last   (load_last),
        .o_load_ready  (load_ready),
        .o_load_done   (load_done),
        .o_load_err    (load_err),
        .o_load_sum    (load_sum),
        .i_fetch_en    (fetch_en),
        .i_pc          (pc),
        .o_instr       (instr),
        .o_instr_valid (instr_valid),
        .o_fetch_fault (fetch_fault),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] ins, input logic flt);
        fetch_en = 1'b1;
        pc       = addr;
        exp_q.push_back({flt, ins});
        @(posedge clk); #1;
        fetch_en = 1'b0;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base);
        load_start = 1'b1;
        load_base  = base;
        @(posedge clk); #1;
        load_start = 1'b0;
        check("ready_after_start", 32'(load_ready), 32'd1);
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic do_word(input logic [31:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        @(posedge clk); #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Monitor: every presented instruction must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (instr_valid) begin
                check("fetch_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("instr", instr, mon_e[31:0]);
                    check("fetch_fault", 32'(fetch_fault), 32'(mon_e[32]));
                end
            end else begin
                check("fault_without_fetch", 32'(fetch_fault), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_load_sum", load_sum, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_instr", instr, ILLOP);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Nothing loaded yet: any fetch faults.
        do_fetch(32'd0, ILLOP, 1'b1);

        // Basic three-word load from base 0.
        do_start(7'd0);
        do_word(32'h0000_0011, 1'b0);
        do_word(32'h0000_0022, 1'b0);
        do_word(32'h0000_0033, 1'b1);
        check("done_pulse", 32'(load_done), 32'd1);
        check("ready_after_last", 32'(load_ready), 32'd0);
        check("busy_after_last", 32'(busy), 32'd0);
        check("sum_basic", load_sum, 32'h0000_0066);
        check("err_basic", 32'(load_err), 32'd0);
        @(posedge clk); #1;
        check("done_single_cycle", 32'(load_done), 32'd0);
        do_fetch(32'd0, 32'h0000_0011, 1'b0);
        do_fetch(32'd4, 32'h0000_0022, 1'b0);
        do_fetch(32'd8, 32'h0000_0033, 1'b0);
        do_fetch(32'd12, ILLOP, 1'b1);
        do_fetch(32'd2, ILLOP, 1'b1);
        do_fetch(32'(4 * DEPTH), ILLOP, 1'b1);

        // Load straddling the top of memory: second word lands beyond DEPTH.
        do_start(7'(DEPTH - 1));
        do_word(32'hAAAA_0001, 1'b0);
        do_word(32'h0000_5555, 1'b1);
        check("err_overflow", 32'(load_err), 32'd1);
        check("sum_overflow", load_sum, 32'hAAAA_0001);
        do_fetch(32'(4 * (DEPTH - 1)), 32'hAAAA_0001, 1'b0);
        do_fetch(32'd0, ILLOP, 1'b1);

        // Streaming load at base 10, load_valid every other cycle, fetch_en held high.
        fetch_en = 1'b1;
        pc       = 32'd0;
        exp_q.push_back({1'b1, ILLOP});
        load_start = 1'b1;
        load_base  = 7'd10;
        @(posedge clk); #1;
        load_start = 1'b0;
        check("err_cleared_on_start", 32'(load_err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b0;
            @(posedge clk); #1;
            load_valid = 1'b1;
            load_last  = (i == 3);
            case (i)
                0: load_data = 32'h8000_0001;
                1: load_data = 32'h8000_0002;
                2: load_data = 32'h0000_1000;
                default: load_data = 32'hFFFF_FFFF;
            endcase
            @(posedge clk); #1;
        end
        fetch_en   = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("stream_done", 32'(load_done), 32'd1);
        check("stream_sum", load_sum, 32'h0000_1002);
        do_fetch(32'd40, 32'h8000_0001, 1'b0);
        do_fetch(32'd44, 32'h8000_0002, 1'b0);
        do_fetch(32'd48, 32'h0000_1000, 1'b0);
        do_fetch(32'd52, 32'hFFFF_FFFF, 1'b0);
        do_fetch(32'd56, ILLOP, 1'b1);
        do_fetch(32'd36, ILLOP, 1'b1);

        // Reset in the middle of a load.
        do_start(7'd0);
        do_word(32'h0000_0101, 1'b0);
        do_word(32'h0000_0202, 1'b0);
        check("sum_before_reset", load_sum, 32'h0000_0303);
        rst = 1'b1;
        #1;
        check("midload_rst_busy", 32'(busy), 32'd0);
        check("midload_rst_sum", load_sum, 32'd0);
        check("midload_rst_ready", 32'(load_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_fetch(32'd0, ILLOP, 1'b1);
        do_fetch(32'd40, ILLOP, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
